// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the phase1 hardwired control unit: states, opcodes,
// ALU select codes and instruction-register field positions.
package control_sequencer_pkg;

   typedef enum logic [2:0] {
      S_RESET = 3'd0,
      S_T0    = 3'd1,
      S_T1    = 3'd2,
      S_T2    = 3'd3,
      S_T3    = 3'd4,
      S_T4    = 3'd5,
      S_T5    = 3'd6,
      S_HALT  = 3'd7
   } state_e;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHL  = 5'b01010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [4:0] ALU_NONE = 5'b00000;
   localparam logic [4:0] ALU_ADD  = 5'b00011;
   localparam logic [4:0] ALU_SUB  = 5'b00100;
   localparam logic [4:0] ALU_SHR  = 5'b00101;
   localparam logic [4:0] ALU_SHL  = 5'b00110;
   localparam logic [4:0] ALU_ROR  = 5'b00111;
   localparam logic [4:0] ALU_ROL  = 5'b01000;
   localparam logic [4:0] ALU_AND  = 5'b01001;
   localparam logic [4:0] ALU_OR   = 5'b01010;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 27;
   localparam int RA_HI  = 26;
   localparam int RA_LO  = 23;
   localparam int RB_HI  = 22;
   localparam int RB_LO  = 19;
   localparam int RC_HI  = 18;
   localparam int RC_LO  = 15;

   function automatic logic is_alu_op(input logic [4:0] op);
      return (op >= OP_ADD) && (op <= OP_SHL);
   endfunction

   function automatic logic [4:0] alu_code(input logic [4:0] op);
      case (op)
         OP_ADD:  return ALU_ADD;
         OP_SUB:  return ALU_SUB;
         OP_AND:  return ALU_AND;
         OP_OR:   return ALU_OR;
         OP_ROR:  return ALU_ROR;
         OP_ROL:  return ALU_ROL;
         OP_SHR:  return ALU_SHR;
         OP_SHL:  return ALU_SHL;
         default: return ALU_NONE;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Strobe bus between the control sequencer (master) and the single-bus datapath (slave).
interface control_sequencer_if #(parameter int NREGS = 16) ();

   logic [31:0]      IR;
   logic             MemReady;
   logic             Stop;
   logic             Start;
   logic             PCout, MARin, Zin, ZLOout, PCin, IncrementPC;
   logic             Read, MDRin, MDRout, IRin, Yin;
   logic [NREGS-1:0] RegIn;
   logic [NREGS-1:0] RegOut;
   logic [4:0]       ALUControl;
   logic             Run;
   logic             Clear;
   logic             Illegal;

   modport master (
      input  IR, MemReady, Stop, Start,
      output PCout, MARin, Zin, ZLOout, PCin, IncrementPC, Read, MDRin, MDRout,
             IRin, Yin, RegIn, RegOut, ALUControl, Run, Clear, Illegal
   );

   modport slave (
      output IR, MemReady, Stop, Start,
      input  PCout, MARin, Zin, ZLOout, PCin, IncrementPC, Read, MDRin, MDRout,
             IRin, Yin, RegIn, RegOut, ALUControl, Run, Clear, Illegal
   );

endinterface

// File: rtl/control_sequencer_reg_select_decode.sv
// One-hot register select; field values beyond the register file select nothing.
module reg_select_decode #(
   parameter int NREGS = 16
) (
   input  logic [3:0]       field_i,
   input  logic             en_i,
   output logic [NREGS-1:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      for (int i = 0; i < NREGS; i++)
         if (en_i && ({28'b0, field_i} == i)) onehot_o[i] = 1'b1;
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer: Moore decode of the state register and IR.
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int NREGS         = 16,
   parameter bit START_RUNNING = 1'b1
) (
   input logic                 Clock,
   input logic                 Reset,
   control_sequencer_if.master bus
);

   state_e     state_q, state_d;
   logic [4:0] opcode;
   logic       alu_op;
   logic [3:0] rout_field;
   logic       rout_en, rin_en;
   logic       unused_ir;

   assign opcode    = bus.IR[OPC_HI:OPC_LO];
   assign alu_op    = is_alu_op(opcode);
   assign unused_ir = ^bus.IR[RC_LO-1:0];

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET: state_d = START_RUNNING ? S_T0 : S_HALT;
         S_T0:    state_d = S_T1;
         S_T1:    state_d = bus.MemReady ? S_T2 : S_T1;
         S_T2:    state_d = S_T3;
         S_T3: begin
            if (alu_op)                 state_d = S_T4;
            else if (opcode == OP_HALT) state_d = S_HALT;
            else                        state_d = bus.Stop ? S_HALT : S_T0;
         end
         S_T4:    state_d = S_T5;
         S_T5:    state_d = bus.Stop ? S_HALT : S_T0;
         S_HALT:  state_d = (bus.Start && !bus.Stop) ? S_T0 : S_HALT;
         default: state_d = S_RESET;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) state_q <= S_RESET;
      else       state_q <= state_d;
   end

   // Rb drives the bus in T3, Rc in T4; only T5 loads Ra.
   assign rout_field = (state_q == S_T4) ? bus.IR[RC_HI:RC_LO] : bus.IR[RB_HI:RB_LO];
   assign rout_en    = ((state_q == S_T3) && alu_op) || (state_q == S_T4);
   assign rin_en     = (state_q == S_T5);

   reg_select_decode #(.NREGS(NREGS)) u_regout (
      .field_i (rout_field),
      .en_i    (rout_en),
      .onehot_o(bus.RegOut)
   );

   reg_select_decode #(.NREGS(NREGS)) u_regin (
      .field_i (bus.IR[RA_HI:RA_LO]),
      .en_i    (rin_en),
      .onehot_o(bus.RegIn)
   );

   always_comb begin
      bus.PCout       = (state_q == S_T0);
      bus.MARin       = (state_q == S_T0);
      bus.IncrementPC = (state_q == S_T0);
      bus.Zin         = (state_q == S_T0) || (state_q == S_T4);
      bus.ZLOout      = (state_q == S_T1) || (state_q == S_T5);
      bus.PCin        = (state_q == S_T1);
      bus.Read        = (state_q == S_T1);
      bus.MDRin       = (state_q == S_T1);
      bus.MDRout      = (state_q == S_T2);
      bus.IRin        = (state_q == S_T2);
      bus.Yin         = (state_q == S_T3) && alu_op;
      bus.ALUControl  = (state_q == S_T4) ? alu_code(opcode) : ALU_NONE;
      bus.Run         = (state_q != S_RESET) && (state_q != S_HALT);
      bus.Clear       = (state_q == S_RESET);
      bus.Illegal     = (state_q == S_T3) && !alu_op &&
                        (opcode != OP_NOP) && (opcode != OP_HALT);
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer; a second NREGS=8, START_RUNNING=0 instance covers
// the halted-after-reset start and out-of-range register fields.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ir;
   logic        mem_ready, stop, start, start2;
   int          checks = 0;
   int          fails  = 0;

   always #5 clk = ~clk;

   control_sequencer_if #(.NREGS(16)) bus ();
   control_sequencer_if #(.NREGS(8))  bus2 ();

   assign bus.IR        = ir;
   assign bus.MemReady  = mem_ready;
   assign bus.Stop      = stop;
   assign bus.Start     = start;
   assign bus2.IR       = ir;
   assign bus2.MemReady = mem_ready;
   assign bus2.Stop     = stop;
   assign bus2.Start    = start2;

   control_sequencer #(.NREGS(16), .START_RUNNING(1'b1)) dut (
      .Clock(clk), .Reset(rst), .bus(bus)
   );

   control_sequencer #(.NREGS(8), .START_RUNNING(1'b0)) dut2 (
      .Clock(clk), .Reset(rst), .bus(bus2)
   );

   // Bit order: PCout MARin Zin ZLOout PCin IncrementPC Read MDRin MDRout IRin Yin
   localparam logic [10:0] ST_NONE = 11'h000;
   localparam logic [10:0] ST_T0   = 11'h720;
   localparam logic [10:0] ST_T1   = 11'h0D8;
   localparam logic [10:0] ST_T2   = 11'h006;
   localparam logic [10:0] ST_T3   = 11'h001;
   localparam logic [10:0] ST_T4   = 11'h100;
   localparam logic [10:0] ST_T5   = 11'h080;

   function automatic logic [10:0] strobes();
      return {bus.PCout, bus.MARin, bus.Zin, bus.ZLOout, bus.PCin, bus.IncrementPC,
              bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin};
   endfunction

   function automatic logic [10:0] strobes2();
      return {bus2.PCout, bus2.MARin, bus2.Zin, bus2.ZLOout, bus2.PCin, bus2.IncrementPC,
              bus2.Read, bus2.MDRin, bus2.MDRout, bus2.IRin, bus2.Yin};
   endfunction

   function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc);
      return {op, ra, rb, rc, 15'b0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_ready = 1'b1; stop = 1'b0; start = 1'b0; start2 = 1'b0; ir = '0;
      tick(); tick();
      checks++;
      if (bus.Clear !== 1'b1) begin fails++; $display("FAIL reset_clear: got %b expected 1", bus.Clear); end
      checks++;
      if (strobes() !== ST_NONE) begin fails++; $display("FAIL reset_strobes: got %h expected %h", strobes(), ST_NONE); end
      checks++;
      if ({bus.Run, bus.Illegal, bus.ALUControl, bus.RegIn, bus.RegOut} !== '0) begin
         fails++; $display("FAIL reset_misc: run=%b ill=%b alu=%h rin=%h rout=%h expected all 0",
                           bus.Run, bus.Illegal, bus.ALUControl, bus.RegIn, bus.RegOut);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (strobes() !== ST_T0) begin fails++; $display("FAIL reset_t0: got %h expected %h", strobes(), ST_T0); end
      checks++;
      if ({bus.Run, bus.Clear} !== 2'b10) begin fails++; $display("FAIL reset_run: got run/clear %b expected 10", {bus.Run, bus.Clear}); end
      checks++;
      if ({bus2.Run, bus2.Clear, strobes2()} !== 13'h0) begin
         fails++; $display("FAIL reset_halt2: got run/clear/strobes %h expected 0", {bus2.Run, bus2.Clear, strobes2()});
      end
   endtask

   task automatic test_alu_and();
      ir = 32'h28918000;
      tick();
      checks++;
      if (strobes() !== ST_T1) begin fails++; $display("FAIL and_t1: got %h expected %h", strobes(), ST_T1); end
      tick();
      checks++;
      if (strobes() !== ST_T2) begin fails++; $display("FAIL and_t2: got %h expected %h", strobes(), ST_T2); end
      tick();
      checks++;
      if ({strobes(), bus.RegOut, bus.ALUControl} !== {ST_T3, 16'h0004, 5'b00000}) begin
         fails++; $display("FAIL and_t3: got strobes %h regout %h alu %b expected %h 0004 00000", strobes(), bus.RegOut, bus.ALUControl, ST_T3);
      end
      tick();
      checks++;
      if ({strobes(), bus.RegOut, bus.ALUControl, bus.RegIn} !== {ST_T4, 16'h0008, 5'b01001, 16'h0000}) begin
         fails++; $display("FAIL and_t4: got strobes %h regout %h alu %b regin %h expected %h 0008 01001 0000",
                           strobes(), bus.RegOut, bus.ALUControl, bus.RegIn, ST_T4);
      end
      tick();
      checks++;
      if ({strobes(), bus.RegIn, bus.RegOut} !== {ST_T5, 16'h0002, 16'h0000}) begin
         fails++; $display("FAIL and_t5: got strobes %h regin %h regout %h expected %h 0002 0000", strobes(), bus.RegIn, bus.RegOut, ST_T5);
      end
      tick();
      checks++;
      if (strobes() !== ST_T0) begin fails++; $display("FAIL and_back_t0: got %h expected %h", strobes(), ST_T0); end
   endtask

   task automatic test_mem_wait();
      int irin_cnt = 0;
      mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (strobes() !== ST_T1) begin fails++; $display("FAIL wait_t1_%0d: got %h expected %h", i, strobes(), ST_T1); end
         if (bus.IRin) irin_cnt++;
         if (i == 3) mem_ready = 1'b1;
         tick();
      end
      checks++;
      if (strobes() !== ST_T2) begin fails++; $display("FAIL wait_t2: got %h expected %h", strobes(), ST_T2); end
      if (bus.IRin) irin_cnt++;
      tick();
      if (bus.IRin) irin_cnt++;
      checks++;
      if (irin_cnt !== 1) begin fails++; $display("FAIL wait_irin_count: got %0d expected 1", irin_cnt); end
      tick(); tick(); tick();
      checks++;
      if (strobes() !== ST_T0) begin fails++; $display("FAIL wait_back_t0: got %h expected %h", strobes(), ST_T0); end
   endtask

   task automatic test_halt_op();
      ir = mk_ir(5'b11011, 4'd1, 4'd2, 4'd3);
      tick(); tick(); tick();
      checks++;
      if ({bus.Run, bus.Illegal, strobes(), bus.RegOut} !== {1'b1, 1'b0, ST_NONE, 16'h0}) begin
         fails++; $display("FAIL halt_t3: got run %b ill %b strobes %h regout %h expected 1 0 000 0000", bus.Run, bus.Illegal, strobes(), bus.RegOut);
      end
      tick();
      checks++;
      if ({bus.Run, strobes()} !== 12'h0) begin fails++; $display("FAIL halt_state: got run/strobes %h expected 0", {bus.Run, strobes()}); end
      start = 1'b1; stop = 1'b1;
      tick();
      checks++;
      if (bus.Run !== 1'b0) begin fails++; $display("FAIL halt_start_and_stop: got run %b expected 0", bus.Run); end
      stop = 1'b0;
      tick();
      start = 1'b0;
      checks++;
      if ({bus.Run, strobes()} !== {1'b1, ST_T0}) begin fails++; $display("FAIL halt_restart: got run/strobes %h expected %h", {bus.Run, strobes()}, {1'b1, ST_T0}); end
   endtask

   task automatic test_stop();
      ir = mk_ir(5'b00011, 4'd4, 4'd5, 4'd6);
      tick(); tick(); tick(); tick();
      checks++;
      if ({bus.RegOut, bus.ALUControl} !== {16'h0040, 5'b00011}) begin
         fails++; $display("FAIL stop_t4: got regout %h alu %b expected 0040 00011", bus.RegOut, bus.ALUControl);
      end
      stop = 1'b1;
      tick();
      checks++;
      if ({strobes(), bus.RegIn} !== {ST_T5, 16'h0010}) begin
         fails++; $display("FAIL stop_t5: got strobes %h regin %h expected %h 0010", strobes(), bus.RegIn, ST_T5);
      end
      tick();
      checks++;
      if ({bus.Run, strobes()} !== 12'h0) begin fails++; $display("FAIL stop_halt: got run/strobes %h expected 0", {bus.Run, strobes()}); end
      stop = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (strobes() !== ST_T0) begin fails++; $display("FAIL stop_restart: got %h expected %h", strobes(), ST_T0); end
   endtask

   task automatic test_illegal();
      int ill_cnt = 0;
      ir = mk_ir(5'b11111, 4'd1, 4'd2, 4'd3);
      tick(); tick();
      if (bus.Illegal) ill_cnt++;
      tick();
      checks++;
      if ({bus.Illegal, bus.Run, strobes()} !== {2'b11, ST_NONE}) begin
         fails++; $display("FAIL illegal_t3: got ill/run/strobes %h expected %h", {bus.Illegal, bus.Run, strobes()}, {2'b11, ST_NONE});
      end
      if (bus.Illegal) ill_cnt++;
      tick();
      if (bus.Illegal) ill_cnt++;
      checks++;
      if (strobes() !== ST_T0) begin fails++; $display("FAIL illegal_back_t0: got %h expected %h", strobes(), ST_T0); end
      checks++;
      if (ill_cnt !== 1) begin fails++; $display("FAIL illegal_pulse_count: got %0d expected 1", ill_cnt); end
   endtask

   task automatic test_reset_mid();
      int rin_cnt = 0;
      ir = 32'h28918000;
      tick(); tick(); tick(); tick();
      checks++;
      if (bus.Zin !== 1'b1 || bus.RegOut !== 16'h0008) begin
         fails++; $display("FAIL rstmid_t4: got zin %b regout %h expected 1 0008", bus.Zin, bus.RegOut);
      end
      rst = 1'b1;
      tick();
      if (bus.RegIn != 0) rin_cnt++;
      checks++;
      if ({bus.Clear, bus.Run, strobes(), bus.RegOut, bus.ALUControl} !== {2'b10, ST_NONE, 16'h0, 5'h0}) begin
         fails++; $display("FAIL rstmid_reset: got clear %b run %b strobes %h regout %h alu %b expected 1 0 000 0000 00000",
                           bus.Clear, bus.Run, strobes(), bus.RegOut, bus.ALUControl);
      end
      rst = 1'b0;
      tick();
      if (bus.RegIn != 0) rin_cnt++;
      checks++;
      if (strobes() !== ST_T0) begin fails++; $display("FAIL rstmid_t0: got %h expected %h", strobes(), ST_T0); end
      checks++;
      if (rin_cnt !== 0) begin fails++; $display("FAIL rstmid_no_regin: got %0d pulses expected 0", rin_cnt); end
   endtask

   task automatic test_nregs8();
      ir = mk_ir(5'b00011, 4'd2, 4'd9, 4'd5);
      checks++;
      if (bus2.Run !== 1'b0) begin fails++; $display("FAIL n8_halted: got run %b expected 0", bus2.Run); end
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      checks++;
      if (strobes2() !== ST_T0) begin fails++; $display("FAIL n8_t0: got %h expected %h", strobes2(), ST_T0); end
      tick(); tick(); tick();
      checks++;
      if ({strobes2(), bus2.RegOut} !== {ST_T3, 8'h00}) begin
         fails++; $display("FAIL n8_t3_out_of_range: got strobes %h regout %h expected %h 00", strobes2(), bus2.RegOut, ST_T3);
      end
      tick();
      checks++;
      if ({bus2.RegOut, bus2.ALUControl} !== {8'h20, 5'b00011}) begin
         fails++; $display("FAIL n8_t4: got regout %h alu %b expected 20 00011", bus2.RegOut, bus2.ALUControl);
      end
      stop = 1'b1;
      tick();
      checks++;
      if (bus2.RegIn !== 8'h04) begin fails++; $display("FAIL n8_t5: got regin %h expected 04", bus2.RegIn); end
      tick();
      checks++;
      if (bus2.Run !== 1'b0) begin fails++; $display("FAIL n8_halt: got run %b expected 0", bus2.Run); end
      stop = 1'b0;
   endtask

   initial begin
      test_reset();
      test_alu_and();
      test_mem_wait();
      test_halt_op();
      test_stop();
      test_illegal();
      test_reset_mid();
      test_nregs8();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
